// File: rtl/umni_pkg.sv
// Shared types, constants and helpers for the UMNI humidity controller.
package umni_pkg;

  typedef enum logic [1:0] {
    DESLIGADO    = 2'd0,
    AGUARDANDO   = 2'd1,
    UMIDIFICANDO = 2'd2,
    SATISFEITO   = 2'd3
  } estado_e;

  localparam int unsigned UMIDADE_MAX = 100;

  // Clamp a humidity reading (or power request) to the physical maximum.
  function automatic int unsigned satura_umidade(input int unsigned valor);
    return (valor > UMIDADE_MAX) ? UMIDADE_MAX : valor;
  endfunction

endpackage

// File: rtl/umni_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced level only
// follows the synchronised input after DEBOUNCE_CICLOS consecutive cycles of a new level.
module umni_debounce #(
  parameter int unsigned DEBOUNCE_CICLOS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic botao_i,
  output logic nivel_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          nivel_q, nivel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: synchroniser shift and stability count; any bounce restarts the count.
  always_comb begin
    sync1_d = botao_i;
    sync2_d = sync1_q;
    nivel_d = nivel_q;
    cnt_d   = '0;
    if (sync2_q != nivel_q) begin
      if (cnt_q == CW'(DEBOUNCE_CICLOS - 1)) begin
        nivel_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      nivel_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      nivel_q <= nivel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nivel_o = nivel_q;

endmodule

// File: rtl/umni_controle_umidade.sv
// Humidity-control core: sensor averaging, sliding temporal mean and hysteresis FSM
// that drives the vaporiser, enabled by debounced push-buttons.
module umni_controle_umidade
  import umni_pkg::*;
#(
  parameter int unsigned N_SENSORES      = 4,
  parameter int unsigned LARGURA         = 7,
  parameter int unsigned LOG2_JANELA     = 2,
  parameter int unsigned HISTERESE       = 2,
  parameter int unsigned DEBOUNCE_CICLOS = 4
) (
  input  logic                          clock_geral,
  input  logic                          reset_geral_n,
  input  logic                          amostra_valida,
  input  logic [N_SENSORES*LARGURA-1:0] sensores,
  input  logic [LARGURA-1:0]            umidade_ref,
  input  logic [LARGURA-1:0]            ajuste_de_modo,
  input  logic                          botao_on_off,
  input  logic                          botao_LED,
  output logic [LARGURA-1:0]            umidade_atual_media,
  output logic [LARGURA-1:0]            umidade_atual_temporal,
  output logic                          media_valida,
  output logic [1:0]                    estado,
  output logic                          umidificador_ligado,
  output logic [LARGURA-1:0]            pot_umidade,
  output logic                          LED_int
);

  localparam int unsigned LOG2_N = $clog2(N_SENSORES);
  localparam int unsigned SSW    = LARGURA + LOG2_N;       // sensor sum width
  localparam int unsigned SW     = LARGURA + LOG2_JANELA;  // window sum width
  localparam int unsigned DEPTH  = 1 << LOG2_JANELA;
  localparam int unsigned FW     = LOG2_JANELA + 1;        // fill counter holds DEPTH
  localparam int unsigned CW     = LARGURA + 1;            // comparison width

  // Stage 1: spatial mean of the saturated sensor words.
  logic [SSW-1:0]     soma_sens;
  logic [LARGURA-1:0] media_q, media_d;
  logic               val1_q, val1_d;

  // Stage 2: circular window and running sum.
  logic [LARGURA-1:0]     janela_q [DEPTH];
  logic [LARGURA-1:0]     janela_d [DEPTH];
  logic [LOG2_JANELA-1:0] ptr_q, ptr_d;
  logic [SW-1:0]          soma_q, soma_d;
  logic [FW-1:0]          fill_q, fill_d;

  // Control.
  logic               nivel_on, nivel_led;
  logic               on_prev_q, on_prev_d, led_prev_q, led_prev_d;
  logic               hab_umid_q, hab_umid_d, hab_led_q, hab_led_d;
  estado_e            state_q, state_d;
  logic [LARGURA-1:0] pot_q, pot_d;
  logic               baixa, alta;
  logic [CW-1:0]      temp_ext;

  umni_debounce #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_deb_on_off (
    .clk_i  (clock_geral),
    .rst_ni (reset_geral_n),
    .botao_i(botao_on_off),
    .nivel_o(nivel_on)
  );

  umni_debounce #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_deb_led (
    .clk_i  (clock_geral),
    .rst_ni (reset_geral_n),
    .botao_i(botao_LED),
    .nivel_o(nivel_led)
  );

  // Stage 1 next-state: saturate, sum and shift; the mean holds between strobes.
  always_comb begin
    soma_sens = '0;
    for (int i = 0; i < int'(N_SENSORES); i++) begin
      soma_sens = soma_sens + SSW'(satura_umidade(32'(sensores[i*LARGURA +: LARGURA])));
    end
    val1_d  = amostra_valida;
    media_d = amostra_valida ? LARGURA'(soma_sens >> LOG2_N) : media_q;
  end

  // Stage 2 next-state: replace the oldest sample and adjust the running sum.
  always_comb begin
    janela_d = janela_q;
    ptr_d    = ptr_q;
    soma_d   = soma_q;
    fill_d   = fill_q;
    if (val1_q) begin
      janela_d[ptr_q] = media_q;
      soma_d          = soma_q + SW'(media_q) - SW'(janela_q[ptr_q]);
      ptr_d           = ptr_q + LOG2_JANELA'(1);
      if (fill_q != FW'(DEPTH)) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  // Comparison flags at one extra bit so temporal + band cannot wrap.
  always_comb begin
    temp_ext = {1'b0, umidade_atual_temporal};
    baixa    = (temp_ext + CW'(HISTERESE)) < {1'b0, umidade_ref};
    alta     = temp_ext >= {1'b0, umidade_ref};
  end

  // Button edge toggles and hysteresis FSM; disabling the humidifier overrides everything.
  always_comb begin
    on_prev_d  = nivel_on;
    led_prev_d = nivel_led;
    hab_umid_d = hab_umid_q ^ (nivel_on & ~on_prev_q);
    hab_led_d  = hab_led_q ^ (nivel_led & ~led_prev_q);
    state_d    = state_q;
    if (!hab_umid_q) begin
      state_d = DESLIGADO;
    end else begin
      unique case (state_q)
        DESLIGADO:    state_d = AGUARDANDO;
        AGUARDANDO:   if (media_valida) state_d = baixa ? UMIDIFICANDO : SATISFEITO;
        UMIDIFICANDO: if (alta) state_d = SATISFEITO;
        SATISFEITO:   if (baixa) state_d = UMIDIFICANDO;
        default:      state_d = DESLIGADO;
      endcase
    end
    pot_d = (state_d == UMIDIFICANDO) ? LARGURA'(satura_umidade(32'(ajuste_de_modo))) : '0;
  end

  // All state registers; reset discards the whole window history.
  always_ff @(posedge clock_geral or negedge reset_geral_n) begin
    if (!reset_geral_n) begin
      media_q    <= '0;
      val1_q     <= 1'b0;
      janela_q   <= '{default: '0};
      ptr_q      <= '0;
      soma_q     <= '0;
      fill_q     <= '0;
      on_prev_q  <= 1'b0;
      led_prev_q <= 1'b0;
      hab_umid_q <= 1'b0;
      hab_led_q  <= 1'b0;
      state_q    <= DESLIGADO;
      pot_q      <= '0;
    end else begin
      media_q    <= media_d;
      val1_q     <= val1_d;
      janela_q   <= janela_d;
      ptr_q      <= ptr_d;
      soma_q     <= soma_d;
      fill_q     <= fill_d;
      on_prev_q  <= on_prev_d;
      led_prev_q <= led_prev_d;
      hab_umid_q <= hab_umid_d;
      hab_led_q  <= hab_led_d;
      state_q    <= state_d;
      pot_q      <= pot_d;
    end
  end

  assign umidade_atual_media    = media_q;
  assign umidade_atual_temporal = LARGURA'(soma_q >> LOG2_JANELA);
  assign media_valida           = (fill_q == FW'(DEPTH));
  assign estado                 = state_q;
  assign umidificador_ligado    = (state_q == UMIDIFICANDO);
  assign pot_umidade            = pot_q;
  assign LED_int                = hab_led_q;

endmodule

// File: doc/umni_controle_umidade.md
# umni_controle_umidade

Parametrised humidity-control core for the UMNI humidifier: averages N humidity sensors, keeps a sliding temporal mean over a configurable window, and drives the vaporiser through a hysteresis state machine enabled by debounced push-buttons. It sits between the sensor front end and the display/actuator drivers. It replaces the fixed 4-sensor / 4-sample datapath with a generalised, deterministic-latency pipeline.

## Interface
Parameters:
- N_SENSORES, 4: number of sensor channels; power of 2, ≥1.
- LARGURA, 7: humidity word width in bits.
- LOG2_JANELA, 2: log2 of the temporal window depth (default window is 4 samples).
- HISTERESE, 2: hysteresis band, in humidity units.
- DEBOUNCE_CICLOS, 4: cycles a synchronised button level must be stable before it is accepted.

Ports:
- clock_geral  in  1  single system clock, rising edge.
- reset_geral_n  in  1  asynchronous, active-low reset.
- amostra_valida  in  1  one-cycle strobe: a new sensor set is present.
- sensores  in  N_SENSORES*LARGURA  packed sensor words; channel 0 is in the LSBs.
- umidade_ref  in  LARGURA  desired humidity.
- ajuste_de_modo  in  LARGURA  requested vaporiser power.
- botao_on_off  in  1  raw humidifier button (asynchronous).
- botao_LED  in  1  raw internal-LED button (asynchronous).
- umidade_atual_media  out  LARGURA  mean of the current sensor set.
- umidade_atual_temporal  out  LARGURA  sliding mean over the window.
- media_valida  out  1  window has been filled at least once.
- estado  out  2  FSM state.
- umidificador_ligado  out  1  vaporiser running.
- pot_umidade  out  LARGURA  applied vaporiser power.
- LED_int  out  1  internal LED.

## Operation
- Each sensor word is saturated to 100 before summing. The sum is LARGURA+log2(N_SENSORES) bits wide. The mean is sum >> log2(N_SENSORES), truncated.
- On each strobe, the mean is written into a circular buffer of depth 2^LOG2_JANELA.
  - A running sum is updated as sum + new − oldest. The sum is LARGURA+LOG2_JANELA bits wide and never overflows.
  - Temporal mean = sum >> LOG2_JANELA.
  - The write pointer wraps modulo the buffer depth.
  - A fill counter saturates at the buffer depth. media_valida rises with the temporal update of the depth-th sample and stays high until reset.
- Button path: 2-FF synchroniser, then debounce. The debounced level changes only after DEBOUNCE_CICLOS consecutive cycles of a new level.
  - A debounced rising edge of botao_on_off toggles hab_umid.
  - A debounced rising edge of botao_LED toggles hab_LED.
- Comparison flags, evaluated every cycle at LARGURA+1 bits:
  - baixa = temporal + HISTERESE < umidade_ref.
  - alta = temporal ≥ umidade_ref.
- FSM states:
  - DESLIGADO=0: go to AGUARDANDO if hab_umid=1.
  - AGUARDANDO=1: once media_valida=1, go to UMIDIFICANDO if baixa, else to SATISFEITO.
  - UMIDIFICANDO=2: go to SATISFEITO if alta.
  - SATISFEITO=3: go to UMIDIFICANDO if baixa.
  - From any state, hab_umid=0 forces DESLIGADO. This rule has top priority.
- Output decoding:
  - umidificador_ligado = (estado==UMIDIFICANDO).
  - pot_umidade = min(ajuste_de_modo,100) in UMIDIFICANDO, else 0.
  - LED_int = hab_LED.

## Timing
- Reset (asynchronous assert, synchronous release): all outputs are 0 and estado=DESLIGADO. Buffer, running sum, fill counter, pointer, hab flags and debounced levels are all cleared.
- Strobe in cycle t produces:
  - umidade_atual_media at t+1;
  - umidade_atual_temporal and media_valida at t+2;
  - estado, umidificador_ligado and pot_umidade at t+3.
- Back-to-back strobes (one every cycle) are fully supported with no loss.
- A raw button level held from cycle t onward changes the debounced level at t+2+DEBOUNCE_CICLOS. The hab flag toggles on the following edge.
- A bounce shorter than DEBOUNCE_CICLOS is ignored and restarts the stability count.
- Changes to umidade_ref or ajuste_de_modo take effect on the next evaluation edge.
- umidade_ref ≤ HISTERESE: baixa can never be true.
- Reset asserted mid-window discards all history; media_valida needs a full window again.
- Clearing hab_umid while in UMIDIFICANDO gives pot_umidade=0 on the next edge. Re-enabling with media_valida already high passes through one AGUARDANDO cycle.

## Structure
- Package umni_pkg holds:
  - the FSM state encoding (DESLIGADO, AGUARDANDO, UMIDIFICANDO, SATISFEITO);
  - the constant UMIDADE_MAX=100;
  - a saturation function.
- One sub-module, umni_debounce (synchroniser plus debounce counter), is instantiated twice.
- Averaging, window buffer and FSM stay in the top module.

## Test plan
Defaults: N=4, window 4, HISTERESE=2, DEBOUNCE_CICLOS=4.
- Sensors 60,62,64,66 strobed 4× -> media=63 each time; media_valida and temporal=63 two cycles after the 4th strobe.
- Sensors 127×4 -> media=100 (saturation). Sensors 0,0,0,3 -> media=0 (truncation).
- Window holding 40,40,40,40, then strobe 80 -> temporal=50. Four more 80 strobes -> temporal=80, exercising pointer wrap.
- Button held 3 cycles -> no toggle. Held 8 cycles -> hab_umid=1, estado AGUARDANDO→SATISFEITO/UMIDIFICANDO, LED untouched.
- Ref=70, ajuste=90, hab_umid=1:
  - temporal 67 -> UMIDIFICANDO, pot=90;
  - temporal 70 -> SATISFEITO, pot=0;
  - temporal 69 -> stays SATISFEITO;
  - temporal 67 -> UMIDIFICANDO.
- In UMIDIFICANDO, assert reset_geral_n=0 for 1 cycle -> all outputs 0 at once, media_valida=0 until 4 new strobes.
